// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI block sequencer: FSM state encoding,
// default block size and the WAIT_DONE watchdog limit.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_DONE = 3'd2,
        GAP       = 3'd3,
        FINISH    = 3'd4
    } spi_seq_state_e;

    localparam int SPI_SEQ_NBYTES  = 16;
    localparam int SPI_SEQ_TIMEOUT = 64;

endpackage

// File: rtl/spi_seq_timer.sv
// Watchdog counter for the sequencer: counts enabled cycles since the last clear
// and flags 'expired' combinationally on the LIMIT-th enabled cycle.
module spi_seq_timer
    import spi_seq_pkg::*;
#(
    parameter int LIMIT = SPI_SEQ_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired = enable && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_block_sequencer.sv
// Sends an NBYTES block through an SPI byte master one byte at a time and collects
// the echoed bytes. Define SPI_SEQ_TIMEOUT_EN to enable the WAIT_DONE watchdog.
module spi_block_sequencer
    import spi_seq_pkg::*;
#(
    parameter int NBYTES     = SPI_SEQ_NBYTES,
    parameter int GAP_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [8*NBYTES-1:0] tx_block,
    output logic                ack,
    output logic                busy,
    output logic [8*NBYTES-1:0] rx_block,
    output logic                rx_valid,
    output logic                err,
    output logic                m_start,
    output logic [7:0]          m_data_in,
    input  logic                m_busy,
    input  logic                m_done,
    input  logic [7:0]          m_data_out,
    output spi_seq_state_e      dbg_state
);
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);

    spi_seq_state_e state_q;
    logic [IW-1:0]  idx_q;
    logic [GW-1:0]  gap_q;
    logic [7:0]     tx_q [NBYTES];
    logic [7:0]     rx_q [NBYTES];
    logic           ack_q, busy_q, rx_valid_q, m_start_q;
    logic [7:0]     m_data_q;

`ifdef SPI_SEQ_TIMEOUT_EN
    logic err_q;
    logic in_wait;
    logic timeout;

    assign in_wait = (state_q == WAIT_DONE);
    assign err     = err_q;

    spi_seq_timer #(.LIMIT(SPI_SEQ_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (timeout)
    );
`else
    assign err = 1'b0;
`endif

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign rx_valid  = rx_valid_q;
    assign m_start   = m_start_q;
    assign m_data_in = m_data_q;
    assign dbg_state = state_q;

    // Byte 0 lives in the most significant byte lane, same as tx_block.
    always_comb begin
        rx_block = '0;
        for (int i = 0; i < NBYTES; i++) begin
            rx_block[8*(NBYTES-1-i) +: 8] = rx_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            m_start_q  <= 1'b0;
            m_data_q   <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            for (int i = 0; i < NBYTES; i++) begin
                tx_q[i] <= '0;
                rx_q[i] <= '0;
            end
        end else begin
            ack_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            m_start_q  <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req && !m_busy) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            tx_q[i] <= tx_block[8*(NBYTES-1-i) +: 8];
                            rx_q[i] <= '0;
                        end
                        idx_q     <= '0;
                        ack_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        m_start_q <= 1'b1;
                        m_data_q  <= tx_block[8*NBYTES-1 -: 8];
                        state_q   <= START;
                    end
                end
                START: state_q <= WAIT_DONE;
                WAIT_DONE: begin
                    if (m_done) begin
                        rx_q[idx_q] <= m_data_out;
                        if (idx_q == LAST_IDX) begin
                            rx_valid_q <= 1'b1;
                            state_q    <= FINISH;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            if (GAP_CYCLES == 0) begin
                                m_start_q <= 1'b1;
                                m_data_q  <= tx_q[idx_q + 1'b1];
                                state_q   <= START;
                            end else begin
                                gap_q   <= '0;
                                state_q <= GAP;
                            end
                        end
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (timeout) begin
                        // Partial data is meaningless after an abort.
                        for (int i = 0; i < NBYTES; i++) begin
                            rx_q[i] <= '0;
                        end
                        err_q   <= 1'b1;
                        state_q <= FINISH;
                    end
`endif
                end
                GAP: begin
                    if (gap_q == LAST_GAP) begin
                        m_start_q <= 1'b1;
                        m_data_q  <= tx_q[idx_q];
                        state_q   <= START;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_block_sequencer.sv
// Directed bench: three sequencers (GAP_CYCLES 2, 0, 3) each driven by an echoing
// byte-master model that answers m_done MDL_K cycles after m_start.
module tb_spi_block_sequencer;
    import spi_seq_pkg::*;

    localparam int MDL_K = 3;
    localparam logic [127:0] BLK0 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK1 = 128'hA55A0FF0C33C96691EE12DD24BB47887;
    localparam logic [127:0] BLK2 = 128'h0102030405060708090A0B0C0D0E0F10;
    localparam logic [127:0] BLK3 = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
    localparam logic [127:0] BLK4 = 128'h13579BDF2468ACE0FDB97531ECA86420;

    logic         clk;
    logic         reset;
    logic         req_a [3];
    logic [127:0] tx_a  [3];
    logic         force_busy;
    logic         force_done;
    int           hold_idx;
    int           cyc;
    int           total;
    int           bad;
    logic [7:0]   exp_q[$];

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_block(input logic [127:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(b[8*(15-i) +: 8]);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int GAP = (g == 0) ? 2 : ((g == 1) ? 0 : 3);

        logic           ack, busy, rx_valid, err, m_start;
        logic [127:0]   rx_block;
        logic [7:0]     m_data_in;
        spi_seq_state_e dbg_state;
        logic           mdl_done = 1'b0;
        logic           mdl_busy = 1'b0;
        logic [7:0]     mdl_dout = '0;
        logic [7:0]     byte_q   = '0;
        int cnt = 0, byte_idx = 0, starts = 0, last_start = 0;
        int ack_cnt = 0, rxv_cnt = 0, err_cnt = 0;
        int ack_cyc = 0, rxv_cyc = 0, err_cyc = 0;
        int bad_gap = 0, hold_bad = 0, excl_bad = 0;

        spi_block_sequencer #(.NBYTES(16), .GAP_CYCLES(GAP)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req        (req_a[g]),
            .tx_block   (tx_a[g]),
            .ack        (ack),
            .busy       (busy),
            .rx_block   (rx_block),
            .rx_valid   (rx_valid),
            .err        (err),
            .m_start    (m_start),
            .m_data_in  (m_data_in),
            .m_busy     (mdl_busy | force_busy),
            .m_done     (mdl_done | force_done),
            .m_data_out (mdl_dout),
            .dbg_state  (dbg_state)
        );

        // Echo slave plus event monitor; inputs change on the falling edge.
        always @(negedge clk) begin
            mdl_done = 1'b0;
            if (reset) begin
                cnt      = 0;
                mdl_busy = 1'b0;
            end else begin
                if (cnt > 0) begin
                    if (m_data_in !== byte_q) hold_bad++;
                    cnt--;
                    if (cnt == 0) begin
                        mdl_done = 1'b1;
                        mdl_dout = byte_q;
                        mdl_busy = 1'b0;
                    end
                end
                if (ack) begin ack_cnt++; ack_cyc = cyc; end
                if (rx_valid) begin rxv_cnt++; rxv_cyc = cyc; end
                if (err) begin err_cnt++; err_cyc = cyc; end
                if (int'(ack) + int'(rx_valid) + int'(err) > 1) excl_bad++;
                if (m_start) begin
                    if (ack) begin
                        byte_idx = 0;
                        starts   = 1;
                    end else begin
                        byte_idx++;
                        starts++;
                        if (cyc - last_start != MDL_K + 1 + GAP) bad_gap++;
                    end
                    last_start = cyc;
                    byte_q     = m_data_in;
                    if (g != 0 || byte_idx != hold_idx) begin
                        cnt      = MDL_K;
                        mdl_busy = 1'b1;
                    end
                end
            end
        end
    end

    // Scoreboard for the byte order presented to the master by instance 0.
    always @(negedge clk) begin
        if (!reset && g_inst[0].m_start) begin
            logic [7:0] exp_b;
            exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : ~g_inst[0].m_data_in;
            check("sb_byte", g_inst[0].m_data_in, exp_b);
        end
    end

    initial begin
        int a0, r0, e0, s;
        total = 0;
        bad = 0;
        hold_idx = -1;
        force_busy = 1'b0;
        force_done = 1'b0;
        for (int g = 0; g < 3; g++) begin
            req_a[g] = 1'b0;
            tx_a[g]  = '0;
        end
        reset = 1'b1;
        tick(3);
        check("rst_ack", g_inst[0].ack, 0);
        check("rst_busy", g_inst[0].busy, 0);
        check("rst_rxv", g_inst[0].rx_valid, 0);
        check("rst_err", g_inst[0].err, 0);
        check("rst_mstart", g_inst[0].m_start, 0);
        check("rst_mdata", g_inst[0].m_data_in, 0);
        check("rst_rxblk", g_inst[0].rx_block, 0);
        check("rst_state", g_inst[0].dbg_state, IDLE);
        reset = 1'b0;
        tick(2);

        // Basic echo transfer
        push_block(BLK0, 16);
        tx_a[0] = BLK0;
        req_a[0] = 1'b1;
        tick(1);
        s = cyc;
        req_a[0] = 1'b0;
        check("acc_ack", g_inst[0].ack, 1);
        check("acc_mstart", g_inst[0].m_start, 1);
        check("acc_byte0", g_inst[0].m_data_in, 8'h00);
        check("acc_busy", g_inst[0].busy, 1);
        check("acc_state", g_inst[0].dbg_state, START);
        tick(110);
        check("t1_rxv_cnt", g_inst[0].rxv_cnt, 1);
        check("t1_rxblk", g_inst[0].rx_block, BLK0);
        check("t1_latency", g_inst[0].rxv_cyc - s, 94);
        check("t1_busy_off", g_inst[0].busy, 0);
        check("t1_starts", g_inst[0].starts, 16);
        check("t1_spacing", g_inst[0].bad_gap, 0);

        // req held high across two back-to-back transfers
        a0 = g_inst[0].ack_cnt;
        r0 = g_inst[0].rxv_cnt;
        push_block(BLK1, 16);
        push_block(BLK1, 16);
        tx_a[0] = BLK1;
        req_a[0] = 1'b1;
        tick(1);
        check("t2_ack1", g_inst[0].ack, 1);
        tick(100);
        check("t2_acks_mid", g_inst[0].ack_cnt - a0, 2);
        check("t2_ack_after_rxv", g_inst[0].ack_cyc - g_inst[0].rxv_cyc, 2);
        req_a[0] = 1'b0;
        tick(100);
        check("t2_acks_end", g_inst[0].ack_cnt - a0, 2);
        check("t2_rxv_cnt", g_inst[0].rxv_cnt - r0, 2);
        check("t2_rxblk", g_inst[0].rx_block, BLK1);

        // Master busy blocks acceptance; stray m_done in IDLE is ignored
        a0 = g_inst[0].ack_cnt;
        r0 = g_inst[0].rxv_cnt;
        force_busy = 1'b1;
        req_a[0] = 1'b1;
        tick(5);
        check("t3_no_ack", g_inst[0].ack_cnt - a0, 0);
        check("t3_busy", g_inst[0].busy, 0);
        force_busy = 1'b0;
        req_a[0] = 1'b0;
        tick(1);
        force_done = 1'b1;
        tick(1);
        force_done = 1'b0;
        tick(2);
        check("t3_rx_hold", g_inst[0].rx_block, BLK1);
        check("t3_no_rxv", g_inst[0].rxv_cnt - r0, 0);
        check("t3_state", g_inst[0].dbg_state, IDLE);

        // Reset during byte 7
        r0 = g_inst[0].rxv_cnt;
        e0 = g_inst[0].err_cnt;
        push_block(BLK2, 16);
        tx_a[0] = BLK2;
        req_a[0] = 1'b1;
        tick(1);
        req_a[0] = 1'b0;
        tick(43);
        check("t4_byte7", g_inst[0].m_data_in, 8'h08);
        check("t4_sb_left", exp_q.size(), 8);
        reset = 1'b1;
        tick(1);
        check("t4_busy", g_inst[0].busy, 0);
        check("t4_mstart", g_inst[0].m_start, 0);
        check("t4_rxblk", g_inst[0].rx_block, 0);
        check("t4_state", g_inst[0].dbg_state, IDLE);
        tick(1);
        reset = 1'b0;
        exp_q.delete();
        tick(120);
        check("t4_no_rxv", g_inst[0].rxv_cnt - r0, 0);
        check("t4_no_err", g_inst[0].err_cnt - e0, 0);

        // GAP_CYCLES = 0 and 3
        tx_a[1] = BLK4;
        tx_a[2] = BLK4;
        req_a[1] = 1'b1;
        req_a[2] = 1'b1;
        tick(1);
        req_a[1] = 1'b0;
        req_a[2] = 1'b0;
        tick(150);
        check("g0_acks", g_inst[1].ack_cnt, 1);
        check("g0_rxv", g_inst[1].rxv_cnt, 1);
        check("g0_rxblk", g_inst[1].rx_block, BLK4);
        check("g0_starts", g_inst[1].starts, 16);
        check("g0_spacing", g_inst[1].bad_gap, 0);
        check("g0_latency", g_inst[1].rxv_cyc - g_inst[1].ack_cyc, 64);
        check("g3_acks", g_inst[2].ack_cnt, 1);
        check("g3_rxv", g_inst[2].rxv_cnt, 1);
        check("g3_rxblk", g_inst[2].rx_block, BLK4);
        check("g3_starts", g_inst[2].starts, 16);
        check("g3_spacing", g_inst[2].bad_gap, 0);
        check("g3_latency", g_inst[2].rxv_cyc - g_inst[2].ack_cyc, 109);

        // m_done withheld on byte 2
        r0 = g_inst[0].rxv_cnt;
        e0 = g_inst[0].err_cnt;
        hold_idx = 2;
        push_block(BLK3, 3);
        tx_a[0] = BLK3;
        req_a[0] = 1'b1;
        tick(1);
        s = cyc;
        req_a[0] = 1'b0;
        tick(100);
`ifdef SPI_SEQ_TIMEOUT_EN
        check("to_err_cnt", g_inst[0].err_cnt - e0, 1);
        check("to_err_delay", g_inst[0].err_cyc - g_inst[0].last_start, 65);
        check("to_err_abs", g_inst[0].err_cyc - s, 77);
        check("to_busy", g_inst[0].busy, 0);
        check("to_rxblk", g_inst[0].rx_block, 0);
        check("to_no_rxv", g_inst[0].rxv_cnt - r0, 0);
        check("to_state", g_inst[0].dbg_state, IDLE);
`else
        check("nt_busy", g_inst[0].busy, 1);
        check("nt_state", g_inst[0].dbg_state, WAIT_DONE);
        check("nt_no_err", g_inst[0].err_cnt - e0, 0);
        check("nt_no_rxv", g_inst[0].rxv_cnt - r0, 0);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("nt_busy_rst", g_inst[0].busy, 0);
`endif
        hold_idx = -1;
        tick(2);

        check("sb_drained", exp_q.size(), 0);
        for (int g = 0; g < 3; g++) begin
            check("excl", g == 0 ? g_inst[0].excl_bad : (g == 1 ? g_inst[1].excl_bad : g_inst[2].excl_bad), 0);
            check("hold", g == 0 ? g_inst[0].hold_bad : (g == 1 ? g_inst[1].hold_bad : g_inst[2].hold_bad), 0);
        end
        check("g0_no_err", g_inst[1].err_cnt, 0);
        check("g3_no_err", g_inst[2].err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_block_sequencer.md
SPI_BLOCK_SEQUENCER -- requirements
Module: spi_block_sequencer

Interface
REQ-001 The block SHALL have parameter NBYTES, default 16: bytes per block transfer (one AES state).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2: idle clk cycles between consecutive bytes (0 allowed).
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port req, input, 1, start a block transfer.
REQ-006 The block SHALL have port tx_block, input, 8*NBYTES, block to send; byte 0 = bits [8*NBYTES-1 -: 8].
REQ-007 The block SHALL have port ack, output, 1, one-cycle pulse when req is accepted.
REQ-008 The block SHALL have port busy, output, 1, high from acceptance until the rx_valid/err cycle inclusive.
REQ-009 The block SHALL have port rx_block, output, 8*NBYTES, received block, same byte ordering as tx_block.
REQ-010 The block SHALL have port rx_valid, output, 1, one-cycle pulse; rx_block complete.
REQ-011 The block SHALL have port err, output, 1, one-cycle pulse; transfer aborted.
REQ-012 The block SHALL have port m_start, output, 1, start pulse to SPI byte master.
REQ-013 The block SHALL have port m_data_in, output, 8, byte to SPI byte master.
REQ-014 The block SHALL have ports m_busy, m_done (input, 1 each) and m_data_out (input, 8): SPI byte master status and received byte.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT_DONE, GAP, FINISH.
REQ-016 In IDLE with req=1 and m_busy=0, the block SHALL latch tx_block, pulse ack, clear byte index, clear rx_block, go to START next cycle.
REQ-017 req while busy=1, or while m_busy=1 in IDLE, SHALL be ignored (no ack, no latch).
REQ-018 START SHALL drive m_start=1 for exactly one cycle, with m_data_in = latched byte[index], then go to WAIT_DONE.
REQ-019 m_data_in SHALL hold the current byte stable from START until m_done.
REQ-020 In WAIT_DONE, on m_done=1, the block SHALL store m_data_out into rx_block byte[index].
REQ-021 After the store, if index = NBYTES-1 the block SHALL go to FINISH; otherwise it SHALL increment index and go to GAP (or directly to START if GAP_CYCLES=0).
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, then go to START.
REQ-023 FINISH SHALL pulse rx_valid for one cycle, then return to IDLE; rx_block SHALL hold its value until the next acceptance.
REQ-024 m_done outside WAIT_DONE SHALL be ignored.
REQ-025 The index counter SHALL be $clog2(NBYTES) bits wide and SHALL never wrap past NBYTES-1.
REQ-026 Cycles per block SHALL be NBYTES*(1 + master byte time) + (NBYTES-1)*GAP_CYCLES + 2 (acceptance + FINISH).
REQ-027 ack, rx_valid and err SHALL be mutually exclusive in any cycle.

Reset
REQ-028 On reset the block SHALL enter IDLE with ack=0, busy=0, rx_valid=0, err=0, m_start=0, m_data_in=0, rx_block=0, index=0.
REQ-029 Reset mid-transfer SHALL abort with no rx_valid and no err pulse.

Configuration
REQ-030 With SPI_SEQ_TIMEOUT_EN defined, a watchdog SHALL count WAIT_DONE cycles; at 64 without m_done it SHALL pulse err, discard the partial rx_block (set to 0) and return to IDLE.
REQ-031 Without SPI_SEQ_TIMEOUT_EN, err SHALL be tied 0 and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-032 Package spi_seq_pkg SHALL hold the FSM state enum, the default NBYTES, and the timeout limit constant (64).
REQ-033 The watchdog SHALL be a sub-module, spi_seq_timer (clear, enable, expired), instantiated only under SPI_SEQ_TIMEOUT_EN.

Verification
REQ-034 tx_block=00112233445566778899AABBCCDDEEFF, slave echo model -> m_data_in sequence 00,11,...,FF; rx_valid once; rx_block equals tx_block.
REQ-035 req held high through a full transfer -> exactly one ack per IDLE entry; a second transfer starts only after rx_valid.
REQ-036 GAP_CYCLES=0 and GAP_CYCLES=3 -> measured start-to-start spacing matches REQ-022 exactly.
REQ-037 Reset asserted during byte 7 -> next cycle busy=0, m_start=0, rx_block=0, no rx_valid.
REQ-038 SPI_SEQ_TIMEOUT_EN defined, m_done withheld on byte 2 -> err pulse 64 cycles after entering WAIT_DONE, busy falls, rx_valid never asserts.
